// File: rtl/register_file_pkg.sv
// Shared constants for the MIPS general-purpose register file: sizes and
// architectural register aliases.
package register_file_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_AT   = 1;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_T0   = 8;
  localparam int REG_S0   = 16;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_FP   = 30;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/register_file_if.sv
// Bus bundle between the writeback stage (write port), the decode stage
// (read ports) and the register file.
interface register_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  // Write port has no backpressure: a write with we=1 is taken on every rising
  // clk. wr_ack is high for the one cycle after a write to a nonzero register.
  // Read ports are combinational, with no handshake.
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic [ADDR_W-1:0] ra0;
  logic [WIDTH-1:0]  rd0;
  logic [ADDR_W-1:0] ra1;
  logic [WIDTH-1:0]  rd1;
  logic              wr_ack;

  modport master (output we, wa, wd, ra0, ra1, input rd0, rd1, wr_ack);
  modport slave  (input we, wa, wd, ra0, ra1, output rd0, rd1, wr_ack);
endinterface

// File: rtl/register_file_demux.sv
// One-hot address decoder for the register-file write path. This is the
// write-side counterpart of the read-side operand muxes.
module demux_1toN
  import register_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    sel,
  output logic [2**ADDR_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/register_file.sv
// MIPS register file: 2**ADDR_W x WIDTH, two combinational read ports and one
// clocked write port. Register $zero always reads 0.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int WRITE_THROUGH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic             wr_en;

  // Writes to $zero are dropped here, so they never enable a register,
  // never raise wr_ack and never bypass.
  assign wr_en = bus.we && (bus.wa != '0);

  demux_1toN #(.ADDR_W(ADDR_W)) u_wr_demux (
    .en     (wr_en),
    .sel    (bus.wa),
    .onehot (wr_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) regs[i] <= bus.wd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.wr_ack <= 1'b0;
    else        bus.wr_ack <= wr_en;
  end

  // When the read address matches an in-flight write, the write data is
  // forwarded so decode sees the writeback value in the same cycle.
  always_comb begin
    bus.rd0 = '0;
    if (bus.ra0 != '0) bus.rd0 = regs[bus.ra0];
    if ((WRITE_THROUGH != 0) && wr_en && (bus.ra0 == bus.wa)) bus.rd0 = bus.wd;
  end

  always_comb begin
    bus.rd1 = '0;
    if (bus.ra1 != '0) bus.rd1 = regs[bus.ra1];
    if ((WRITE_THROUGH != 0) && wr_en && (bus.ra1 == bus.wa)) bus.rd1 = bus.wd;
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: write-through and non-bypass instances are driven
// in lockstep and compared against an array model of the architectural registers.
module tb_register_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_file_if #(.WIDTH(32), .ADDR_W(5)) bus_wt ();
  register_file_if #(.WIDTH(32), .ADDR_W(5)) bus_nb ();

  register_file #(.WIDTH(32), .ADDR_W(5), .WRITE_THROUGH(1)) dut_wt (
    .clk(clk), .rst_n(rst_n), .bus(bus_wt));
  register_file #(.WIDTH(32), .ADDR_W(5), .WRITE_THROUGH(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus_nb));

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [32];
  logic        exp_ack;
  logic        cur_we;
  logic [4:0]  cur_wa, cur_ra0, cur_ra1;
  logic [31:0] cur_wd;

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    cur_we = we; cur_wa = wa; cur_wd = wd; cur_ra0 = ra0; cur_ra1 = ra1;
    bus_wt.we = we; bus_wt.wa = wa; bus_wt.wd = wd; bus_wt.ra0 = ra0; bus_wt.ra1 = ra1;
    bus_nb.we = we; bus_nb.wa = wa; bus_nb.wd = wd; bus_nb.ra0 = ra0; bus_nb.ra1 = ra1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    exp_ack = 1'b0;
  endtask

  // Architectural view: $zero reads 0, a pending write is visible early only
  // with write-through, otherwise the stored value is returned.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit wt);
    if (ra == 5'd0) return 32'd0;
    if (wt && cur_we && cur_wa != 5'd0 && ra == cur_wa) return cur_wd;
    return model_mem[ra];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (cur_we && cur_wa != 5'd0) model_mem[cur_wa] = cur_wd;
      exp_ack = cur_we && (cur_wa != 5'd0);
    end
    #1;
  endtask

  task automatic test_reset();
    // Fill a few registers so the reset has something to clear.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({bus_wt.wr_ack, bus_nb.wr_ack} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ack: got %b%b expected 00", bus_wt.wr_ack, bus_nb.wr_ack);
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      #1;
      checks++;
      if ({bus_wt.rd0, bus_wt.rd1, bus_nb.rd0, bus_nb.rd1} !== 128'd0) begin
        errors++;
        $display("FAIL reset_read ra=%0d: got %h %h %h %h expected 0", i,
                 bus_wt.rd0, bus_wt.rd1, bus_nb.rd0, bus_nb.rd1);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 5'd5, 32'd123456, 5'd5, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    #1;
    checks++;
    if ({bus_wt.rd0, bus_nb.rd0, bus_nb.rd1} !== {3{32'd123456}}) begin
      errors++;
      $display("FAIL basic_read: got %0d %0d %0d expected 123456", bus_wt.rd0, bus_nb.rd0, bus_nb.rd1);
    end
    checks++;
    if ({bus_wt.wr_ack, bus_nb.wr_ack} !== 2'b11) begin
      errors++;
      $display("FAIL basic_ack: got %b%b expected 11", bus_wt.wr_ack, bus_nb.wr_ack);
    end
    tick();
    checks++;
    if ({bus_wt.wr_ack, bus_nb.wr_ack} !== 2'b00) begin
      errors++;
      $display("FAIL basic_ack_idle: got %b%b expected 00", bus_wt.wr_ack, bus_nb.wr_ack);
    end
    checks++;
    if ({bus_wt.rd0, bus_nb.rd0} !== {2{32'd123456}}) begin
      errors++;
      $display("FAIL basic_hold: got %0d %0d expected 123456", bus_wt.rd0, bus_nb.rd0);
    end
  endtask

  task automatic test_zero();
    drive(1'b1, 5'd0, 32'd555555, 5'd0, 5'd0);
    #1;
    checks++;
    if ({bus_wt.rd0, bus_wt.rd1, bus_nb.rd0} !== 96'd0) begin
      errors++;
      $display("FAIL zero_bypass: got %0d %0d %0d expected 0", bus_wt.rd0, bus_wt.rd1, bus_nb.rd0);
    end
    tick();
    checks++;
    if ({bus_wt.wr_ack, bus_nb.wr_ack} !== 2'b00) begin
      errors++;
      $display("FAIL zero_ack: got %b%b expected 00", bus_wt.wr_ack, bus_nb.wr_ack);
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(i));
      #1;
      checks++;
      if ({bus_wt.rd0, bus_nb.rd1} !== {2{model_mem[i]}}) begin
        errors++;
        $display("FAIL zero_other ra=%0d: got %h %h expected %h", i, bus_wt.rd0, bus_nb.rd1, model_mem[i]);
      end
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'd10, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 32'd20, 5'd7, 5'd7);
    #1;
    checks++;
    if ({bus_wt.rd0, bus_wt.rd1} !== {32'd20, 32'd20}) begin
      errors++;
      $display("FAIL bypass_wt: got %0d %0d expected 20 20", bus_wt.rd0, bus_wt.rd1);
    end
    checks++;
    if ({bus_nb.rd0, bus_nb.rd1} !== {32'd10, 32'd10}) begin
      errors++;
      $display("FAIL bypass_nb_pre: got %0d %0d expected 10 10", bus_nb.rd0, bus_nb.rd1);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    #1;
    checks++;
    if ({bus_nb.rd0, bus_nb.rd1, bus_wt.rd0} !== {3{32'd20}}) begin
      errors++;
      $display("FAIL bypass_post: got %0d %0d %0d expected 20", bus_nb.rd0, bus_nb.rd1, bus_wt.rd0);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 5'd0, 5'd0);
      tick();
      if (bus_wt.wr_ack === 1'b1 && bus_nb.wr_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 31) begin
      errors++;
      $display("FAIL sweep_ack: got %0d cycles high expected 31", acks);
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] want;
      want = (i == 0) ? 32'd0 : 32'h100 + 32'(i);
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      #1;
      checks++;
      if ({bus_wt.rd0, bus_nb.rd0} !== {2{want}}) begin
        errors++;
        $display("FAIL sweep_read ra=%0d: got %h %h expected %h", i, bus_wt.rd0, bus_nb.rd0, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd3, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    drive(1'b1, 5'd3, 32'd1, 5'd0, 5'd0);
    #4 rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    #1;
    checks++;
    if ({bus_wt.rd0, bus_nb.rd1} !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_reg: got %h %h expected 0", bus_wt.rd0, bus_nb.rd1);
    end
    checks++;
    if ({bus_wt.wr_ack, bus_nb.wr_ack} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_ack: got %b%b expected 00", bus_wt.wr_ack, bus_nb.wr_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd3, 32'd1, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    #1;
    checks++;
    if ({bus_wt.wr_ack, bus_nb.wr_ack, bus_wt.rd0, bus_nb.rd0} !== {2'b11, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL reset_mid_after: got ack %b%b rd %h %h expected ack 11 rd 1",
               bus_wt.wr_ack, bus_nb.wr_ack, bus_wt.rd0, bus_nb.rd0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom), 5'($urandom));
      #1;
      checks++;
      if ({bus_wt.rd0, bus_wt.rd1} !== {exp_rd(cur_ra0, 1'b1), exp_rd(cur_ra1, 1'b1)}) begin
        errors++;
        $display("FAIL rand_wt n=%0d: got %h %h expected %h %h", n, bus_wt.rd0, bus_wt.rd1,
                 exp_rd(cur_ra0, 1'b1), exp_rd(cur_ra1, 1'b1));
      end
      checks++;
      if ({bus_nb.rd0, bus_nb.rd1} !== {exp_rd(cur_ra0, 1'b0), exp_rd(cur_ra1, 1'b0)}) begin
        errors++;
        $display("FAIL rand_nb n=%0d: got %h %h expected %h %h", n, bus_nb.rd0, bus_nb.rd1,
                 exp_rd(cur_ra0, 1'b0), exp_rd(cur_ra1, 1'b0));
      end
      tick();
      checks++;
      if ({bus_wt.wr_ack, bus_nb.wr_ack} !== {2{exp_ack}}) begin
        errors++;
        $display("FAIL rand_ack n=%0d: got %b%b expected %b", n, bus_wt.wr_ack, bus_nb.wr_ack, exp_ack);
      end
    end
  endtask

  initial begin
    model_clear();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
